alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//   Initiator/driver for alu_with_memory. Accepts one ALU command on a valid/ready port.
//   Drives the ALU operands, waits for the ALU done signal, then commits the result
//   into the ALU register file. Optionally reads the register back and checks it.
//   Returns result/status on a valid/ready response port. Sits between a host/test
//   controller and alu_with_memory.
// PARAMETERS
//   OPW      2   operand/ctrl/reg-address width
//   RW       4   ALU result (y) and reg_data width
//   TIMEOUT  15  max WAIT_DONE cycles before abort (1..255)
// PORTS
//   clk          in   1    clock, all logic on rising edge
//   reset        in   1    asynchronous, active-high reset
//   cmd_valid    in   1    command present
//   cmd_ready    out  1    sequencer can accept command
//   cmd_a        in   OPW  operand a
//   cmd_b        in   OPW  operand b
//   cmd_ctrl     in   OPW  ALU op (00 ADD, 01 SUB, others passed through)
//   cmd_dest     in   OPW  destination register address
//   alu_a        out  OPW  to ALU a
//   alu_b        out  OPW  to ALU b
//   alu_ctrl     out  OPW  to ALU ctrl
//   alu_reg_addr out  OPW  to ALU reg_addr
//   alu_reg_write out 1    to ALU reg_write
//   alu_y        in   RW   from ALU y
//   alu_c        in   1    from ALU carry/borrow c
//   alu_done     in   1    from ALU done
//   alu_reg_data in   RW   from ALU reg_data (register selected by reg_addr)
//   rsp_valid    out  1    response present
//   rsp_ready    in   1    response consumed
//   rsp_y        out  RW   captured ALU result
//   rsp_c        out  1    captured carry
//   rsp_err      out  1    1 = ALU timeout; result not written
//   rsp_mismatch out  1    1 = readback != rsp_y (0 when check compiled out)
// BEHAVIOUR
//   - Reset (async) forces IDLE and sets all outputs to 0, alu_reg_write=0 immediately.
//     This holds even mid-operation. No partial response survives reset.
//   - FSM: IDLE -> DRIVE -> WAIT_DONE -> WRITE -> [READBACK] -> RESP -> IDLE.
//   - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch a/b/ctrl/dest onto the alu_* outputs.
//     The alu_* outputs stay stable until the next accept. Go to DRIVE.
//   - DRIVE: 1 cycle. alu_done is ignored here (stale done from the previous op).
//   - WAIT_DONE: an 8-bit counter starts at 0. On alu_done=1, capture alu_y/alu_c and
//     go to WRITE. When the counter reaches TIMEOUT without done, set rsp_err=1 and go
//     to RESP, skipping WRITE.
//   - WRITE: exactly one cycle with alu_reg_write=1 and alu_reg_addr=dest.
//   - RESP: rsp_valid=1. All rsp_* fields are stable until rsp_valid&rsp_ready,
//     then go to IDLE.
//   - cmd_ready=0 in every state except IDLE. A new command is accepted no earlier than
//     the cycle after the response handshake.
//   - Latency, done first seen at WAIT_DONE cycle k (accept = cycle 0, k>=2):
//     rsp_valid rises at cycle k+3 with check, k+2 without.
//   - Widths: rsp_y is alu_y unmodified (RW bits). No internal arithmetic except the
//     timeout counter, which saturates and never wraps.
// CONFIGURATION
//   SEQ_READBACK_CHECK_EN defined: a READBACK state follows WRITE. In READBACK,
//     alu_reg_write=0 and alu_reg_addr=dest. alu_reg_data is sampled at the end of that
//     cycle and rsp_mismatch = (alu_reg_data != rsp_y).
//   Not defined: WRITE goes directly to RESP, and rsp_mismatch is tied to 0.
// TESTING
//   1. ADD a=10 b=11 dest=00, done 3 cycles after DRIVE -> rsp_y=0101 rsp_c=0 rsp_err=0;
//      exactly one alu_reg_write pulse with addr 00.
//   2. SUB a=11 b=01 dest=01 -> rsp_y=0010, write pulse to addr 01;
//      with check enabled and a correct model, rsp_mismatch=0.
//   3. alu_done held 0 -> rsp_valid after 15 WAIT_DONE cycles with rsp_err=1;
//      alu_reg_write never asserted.
//   4. rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, cmd_ready=0,
//      cmd_valid ignored; accept resumes the cycle after the handshake.
//   5. Reset asserted in WAIT_DONE -> all outputs 0 the same cycle; after release,
//      cmd_ready=1 and a fresh ADD completes normally.
//   6. SEQ_READBACK_CHECK_EN, model returns reg_data=0000 for y=0101 -> rsp_mismatch=1.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for alu_with_memory: drives operands, waits for done, commits the result, responds.
// Optional register readback check is enabled by defining SEQ_READBACK_CHECK_EN.
module alu_cmd_sequencer #(
   parameter int unsigned OPW     = 2,
   parameter int unsigned RW      = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [OPW-1:0] cmd_a,
   input  logic [OPW-1:0] cmd_b,
   input  logic [OPW-1:0] cmd_ctrl,
   input  logic [OPW-1:0] cmd_dest,
   output logic [OPW-1:0] alu_a,
   output logic [OPW-1:0] alu_b,
   output logic [OPW-1:0] alu_ctrl,
   output logic [OPW-1:0] alu_reg_addr,
   output logic           alu_reg_write,
   input  logic [RW-1:0]  alu_y,
   input  logic           alu_c,
   input  logic           alu_done,
   input  logic [RW-1:0]  alu_reg_data,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [RW-1:0]  rsp_y,
   output logic           rsp_c,
   output logic           rsp_err,
   output logic           rsp_mismatch
);

   localparam int unsigned CW = 8;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_WAIT,
      S_WRITE,
      S_READBACK,
      S_RESP
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [OPW-1:0] a_q, a_d, b_q, b_d, ctrl_q, ctrl_d, addr_q, addr_d;
   logic           write_q, write_d;
   logic           cmd_ready_q, cmd_ready_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [RW-1:0]  rsp_y_q, rsp_y_d;
   logic           rsp_c_q, rsp_c_d;
   logic           rsp_err_q, rsp_err_d;
`ifdef SEQ_READBACK_CHECK_EN
   logic           rsp_mm_q, rsp_mm_d;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      ctrl_d      = ctrl_q;
      addr_d      = addr_q;
      write_d     = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_y_d     = rsp_y_q;
      rsp_c_d     = rsp_c_q;
      rsp_err_d   = rsp_err_q;
`ifdef SEQ_READBACK_CHECK_EN
      rsp_mm_d    = rsp_mm_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               a_d       = cmd_a;
               b_d       = cmd_b;
               ctrl_d    = cmd_ctrl;
               addr_d    = cmd_dest;
               rsp_err_d = 1'b0;
`ifdef SEQ_READBACK_CHECK_EN
               rsp_mm_d  = 1'b0;
`endif
               state_d   = S_DRIVE;
            end
         end
         S_DRIVE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A done in the final allowed cycle still wins over the abort
            if (alu_done) begin
               rsp_y_d   = alu_y;
               rsp_c_d   = alu_c;
               rsp_err_d = 1'b0;
               write_d   = 1'b1;
               state_d   = S_WRITE;
            end else if (cnt_q >= CNT_LAST) begin
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WRITE: begin
`ifdef SEQ_READBACK_CHECK_EN
            state_d = S_READBACK;
`else
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
`endif
         end
`ifdef SEQ_READBACK_CHECK_EN
         S_READBACK: begin
            rsp_mm_d    = (alu_reg_data != rsp_y_q);
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
         end
`endif
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      cmd_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         ctrl_q      <= '0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_y_q     <= '0;
         rsp_c_q     <= 1'b0;
         rsp_err_q   <= 1'b0;
`ifdef SEQ_READBACK_CHECK_EN
         rsp_mm_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         ctrl_q      <= ctrl_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_y_q     <= rsp_y_d;
         rsp_c_q     <= rsp_c_d;
         rsp_err_q   <= rsp_err_d;
`ifdef SEQ_READBACK_CHECK_EN
         rsp_mm_q    <= rsp_mm_d;
`endif
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign alu_a         = a_q;
   assign alu_b         = b_q;
   assign alu_ctrl      = ctrl_q;
   assign alu_reg_addr  = addr_q;
   assign alu_reg_write = write_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_y         = rsp_y_q;
   assign rsp_c         = rsp_c_q;
   assign rsp_err       = rsp_err_q;
`ifdef SEQ_READBACK_CHECK_EN
   assign rsp_mismatch  = rsp_mm_q;
`else
   logic unused_reg_data;
   assign unused_reg_data = ^alu_reg_data;
   assign rsp_mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: bench-side ALU with register file, per-cycle expectations
// derived from accept/done/handshake cycle offsets. Honours SEQ_READBACK_CHECK_EN.
module tb_alu_cmd_sequencer;

   localparam int unsigned OPW     = 2;
   localparam int unsigned RW      = 4;
   localparam int          TIMEOUT = 15;
`ifdef SEQ_READBACK_CHECK_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif

   logic           clk, reset;
   logic           cmd_valid, cmd_ready;
   logic [OPW-1:0] cmd_a, cmd_b, cmd_ctrl, cmd_dest;
   logic [OPW-1:0] alu_a, alu_b, alu_ctrl, alu_reg_addr;
   logic           alu_reg_write;
   logic [RW-1:0]  alu_y;
   logic           alu_c, alu_done;
   logic [RW-1:0]  alu_reg_data;
   logic           rsp_valid, rsp_ready;
   logic [RW-1:0]  rsp_y;
   logic           rsp_c, rsp_err, rsp_mismatch;

   alu_cmd_sequencer #(.OPW(OPW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ctrl(cmd_ctrl), .cmd_dest(cmd_dest),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_reg_addr(alu_reg_addr),
      .alu_reg_write(alu_reg_write),
      .alu_y(alu_y), .alu_c(alu_c), .alu_done(alu_done), .alu_reg_data(alu_reg_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_y(rsp_y), .rsp_c(rsp_c), .rsp_err(rsp_err), .rsp_mismatch(rsp_mismatch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench-side ALU register file; corrupt forces readback data to zero
   logic [RW-1:0] regs [4];
   logic          corrupt;
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (alu_reg_write) begin
         regs[alu_reg_addr] <= alu_y;
      end
   end
   assign alu_reg_data = corrupt ? '0 : regs[alu_reg_addr];

   function automatic logic [RW:0] alu_fn(input logic [1:0] a, input logic [1:0] b, input logic [1:0] ctrl);
      logic [RW-1:0] y;
      logic          c;
      case (ctrl)
         2'b00:   begin y = 4'(a) + 4'(b); c = 1'b0;    end
         2'b01:   begin y = 4'(a) - 4'(b); c = (a < b); end
         default: begin y = {a, b};        c = ^ctrl;   end
      endcase
      return {c, y};
   endfunction

   // Expectations for the current cycle, written by the stimulus process
   logic           chk_on;
   logic           exp_cmd_ready, exp_write, exp_rsp_valid, exp_err, exp_c, exp_mm;
   logic [OPW-1:0] exp_a, exp_b, exp_ctrl, exp_addr;
   logic [RW-1:0]  exp_y;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare process: every cycle, away from the active edge
   logic          prev_v = 1'b0;
   logic [RW-1:0] snap_y;
   logic          snap_c, snap_err, snap_mm;
   always @(negedge clk) begin
      if (chk_on) begin
         check("cmd_ready",     32'(cmd_ready),     32'(exp_cmd_ready));
         check("alu_reg_write", 32'(alu_reg_write), 32'(exp_write));
         check("rsp_valid",     32'(rsp_valid),     32'(exp_rsp_valid));
         check("alu_a",         32'(alu_a),         32'(exp_a));
         check("alu_b",         32'(alu_b),         32'(exp_b));
         check("alu_ctrl",      32'(alu_ctrl),      32'(exp_ctrl));
         check("alu_reg_addr",  32'(alu_reg_addr),  32'(exp_addr));
         if (exp_rsp_valid) begin
            check("rsp_err",      32'(rsp_err),      32'(exp_err));
            check("rsp_mismatch", 32'(rsp_mismatch), 32'(exp_mm));
            if (!exp_err) begin
               check("rsp_y", 32'(rsp_y), 32'(exp_y));
               check("rsp_c", 32'(rsp_c), 32'(exp_c));
            end
            if (prev_v) begin
               check("rsp_y_stable",   32'(rsp_y),        32'(snap_y));
               check("rsp_c_stable",   32'(rsp_c),        32'(snap_c));
               check("rsp_err_stable", 32'(rsp_err),      32'(snap_err));
               check("rsp_mm_stable",  32'(rsp_mismatch), 32'(snap_mm));
            end
            snap_y   = rsp_y;
            snap_c   = rsp_c;
            snap_err = rsp_err;
            snap_mm  = rsp_mismatch;
         end
         if (reset) begin
            check("rst_rsp_y",  32'(rsp_y),        32'd0);
            check("rst_rsp_c",  32'(rsp_c),        32'd0);
            check("rst_rsp_err", 32'(rsp_err),     32'd0);
            check("rst_rsp_mm", 32'(rsp_mismatch), 32'd0);
         end
         prev_v = exp_rsp_valid;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_exp();
      exp_cmd_ready = 1'b0; exp_write = 1'b0; exp_rsp_valid = 1'b0;
      exp_a = '0; exp_b = '0; exp_ctrl = '0; exp_addr = '0;
      exp_err = 1'b0; exp_y = '0; exp_c = 1'b0; exp_mm = 1'b0;
   endtask

   task automatic quiet_inputs();
      cmd_valid = 1'b0; rsp_ready = 1'b0; alu_done = 1'b0; corrupt = 1'b0;
   endtask

   // Reset applied mid-cycle (after an edge); outputs must clear without a clock
   task automatic apply_reset(input int n);
      reset = 1'b1;
      quiet_inputs();
      zero_exp();
      repeat (n) next_cycle();
      reset = 1'b0;
      next_cycle();
      exp_cmd_ready = 1'b1;
   endtask

   // One command. k: cycle (accept = 0) where done is driven; 0 = never.
   task automatic txn(input logic [1:0] a, input logic [1:0] b, input logic [1:0] ctrl,
                      input logic [1:0] dest, input int k, input int hold, input bit corrupt_i,
                      input bit use_lit, input logic [RW-1:0] lit_y, input bit lit_c);
      logic [RW:0] res;
      bit          to;
      int          r, h;
      res = alu_fn(a, b, ctrl);
      to  = (k == 0) || (k > TIMEOUT + 1);
      r   = to ? TIMEOUT + 2 : k + 2 + CHK;
      h   = r + hold;
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_ctrl = ctrl; cmd_dest = dest;
      corrupt = corrupt_i;
      for (int t = 1; t <= h; t++) begin
         next_cycle();
         cmd_valid = 1'($urandom);
         cmd_a = 2'($urandom); cmd_b = 2'($urandom); cmd_ctrl = 2'($urandom); cmd_dest = 2'($urandom);
         alu_done  = (t == 1) ? 1'($urandom) : (t == k);
         if (!to && t >= k) begin
            alu_y = res[RW-1:0]; alu_c = res[RW];
         end else begin
            alu_y = 4'($urandom); alu_c = 1'($urandom);
         end
         rsp_ready     = (t < r) ? 1'($urandom) : (t == h);
         exp_cmd_ready = 1'b0;
         exp_a = a; exp_b = b; exp_ctrl = ctrl; exp_addr = dest;
         exp_write     = !to && (t == k + 1);
         exp_rsp_valid = (t >= r);
         exp_err       = to;
         exp_y         = use_lit ? lit_y : res[RW-1:0];
         exp_c         = use_lit ? lit_c : res[RW];
         exp_mm        = (CHK != 0) && !to && corrupt_i && (res[RW-1:0] != '0);
      end
      next_cycle();
      quiet_inputs();
      exp_cmd_ready = 1'b1; exp_rsp_valid = 1'b0; exp_write = 1'b0;
   endtask

   // Accept a command, then reset while it waits for done
   task automatic reset_in_wait(input logic [1:0] a, input logic [1:0] b, input logic [1:0] ctrl,
                                input logic [1:0] dest);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_ctrl = ctrl; cmd_dest = dest;
      for (int t = 1; t <= 4; t++) begin
         next_cycle();
         cmd_valid = 1'b0; alu_done = 1'b0;
         exp_cmd_ready = 1'b0;
         exp_a = a; exp_b = b; exp_ctrl = ctrl; exp_addr = dest;
      end
      apply_reset(2);
   endtask

   initial begin
      chk_on = 1'b0;
      reset  = 1'b1;
      quiet_inputs();
      cmd_a = '0; cmd_b = '0; cmd_ctrl = '0; cmd_dest = '0;
      alu_y = '0; alu_c = 1'b0;
      zero_exp();
      next_cycle();
      chk_on = 1'b1;
      apply_reset(2);

      txn(2'b10, 2'b11, 2'b00, 2'b00, 4,  0, 1'b0, 1'b1, 4'b0101, 1'b0);
      txn(2'b11, 2'b01, 2'b01, 2'b01, 5,  1, 1'b0, 1'b1, 4'b0010, 1'b0);
      txn(2'b01, 2'b01, 2'b00, 2'b10, 0,  0, 1'b0, 1'b0, 4'b0000, 1'b0);
      txn(2'b01, 2'b10, 2'b10, 2'b11, 3,  5, 1'b0, 1'b1, 4'b0110, 1'b1);
      reset_in_wait(2'b11, 2'b11, 2'b00, 2'b01);
      txn(2'b10, 2'b11, 2'b00, 2'b00, 4,  0, 1'b0, 1'b1, 4'b0101, 1'b0);
      txn(2'b10, 2'b11, 2'b00, 2'b10, 4,  2, 1'b1, 1'b1, 4'b0101, 1'b0);
      txn(2'b00, 2'b11, 2'b01, 2'b11, 2,  0, 1'b0, 1'b1, 4'b1101, 1'b1);
      txn(2'b11, 2'b11, 2'b00, 2'b01, 16, 0, 1'b0, 1'b1, 4'b0110, 1'b0);
      txn(2'b11, 2'b11, 2'b00, 2'b01, 17, 1, 1'b0, 1'b0, 4'b0000, 1'b0);

      for (int i = 0; i < 40; i++) begin
         int k;
         k = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 18));
         txn(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), k,
             int'($urandom_range(0, 3)), 1'($urandom), 1'b0, 4'b0000, 1'b0);
      end

      next_cycle();
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
